dispatch: RTL

DISPATCH -- requirements
Module: dispatch

---
 rtl/gpu_pkg.sv | 22 ++
 rtl/dispatch_slot.sv | 41 ++++
 rtl/dispatch.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared dispatcher types and constants: FSM state encoding, bus widths and block-count helper.
package gpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DONE     = 2'd2
  } dispatch_state_e;

  localparam int unsigned TC_W    = 8;
  localparam int unsigned BLOCK_W = 8;
  localparam int unsigned PERF_W  = 16;

  // ceil(tc / 2**tpb_log2), carried in one extra bit so tc=255 cannot wrap
  function automatic logic [BLOCK_W-1:0] block_count(input logic [TC_W-1:0] tc,
                                                     input int unsigned tpb_log2);
    logic [TC_W:0] sum;
    sum = {1'b0, tc} + ((TC_W+1)'(1) << tpb_log2) - (TC_W+1)'(1);
    return BLOCK_W'(sum >> tpb_log2);
  endfunction

endpackage

// File: rtl/dispatch_slot.sv
// Per-core run/hold state: takes a block assignment, releases the core when it reports done.
module dispatch_slot
  import gpu_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               assign_en,
  input  logic [BLOCK_W-1:0] block_id,
  input  logic [CNT_W-1:0]   thread_cnt,
  input  logic               core_done,
  output logic               core_start,
  output logic               core_reset,
  output logic [BLOCK_W-1:0] core_block_id,
  output logic [CNT_W-1:0]   core_thread_count,
  output logic               release_c
);

  // done from an idle core is ignored
  assign release_c = core_start & core_done;

  // assign_en only targets a core already in reset, so it never collides with a release
  always_ff @(posedge clk) begin
    if (reset) begin
      core_start        <= 1'b0;
      core_reset        <= 1'b1;
      core_block_id     <= '0;
      core_thread_count <= '0;
    end else if (assign_en) begin
      core_start        <= 1'b1;
      core_reset        <= 1'b0;
      core_block_id     <= block_id;
      core_thread_count <= thread_cnt;
    end else if (release_c) begin
      core_start <= 1'b0;
      core_reset <= 1'b1;
    end
  end

endmodule

// File: rtl/dispatch.sv
// Kernel block dispatcher: splits a launch into blocks and feeds them to free cores.
// Optional DISPATCH_PERF_EN adds a saturating kernel_cycles counter of DISPATCH edges.
module dispatch
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_CORES         = 2,
  parameter int unsigned THREADS_PER_BLOCK = 4
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic [TC_W-1:0]                                      thread_count,
  input  logic [NUM_CORES-1:0]                                 core_done,
  output logic [NUM_CORES-1:0]                                 core_start,
  output logic [NUM_CORES-1:0]                                 core_reset,
  output logic [NUM_CORES-1:0][BLOCK_W-1:0]                    core_block_id,
  output logic [NUM_CORES-1:0][$clog2(THREADS_PER_BLOCK):0]    core_thread_count,
`ifdef DISPATCH_PERF_EN
  output logic [PERF_W-1:0]                                    kernel_cycles,
`endif
  output logic                                                 done
);

  localparam int unsigned TPB_LOG2 = $clog2(THREADS_PER_BLOCK);
  localparam int unsigned CNT_W    = TPB_LOG2 + 1;

  dispatch_state_e      state;
  logic [TC_W-1:0]      tc_q;
  logic [BLOCK_W-1:0]   total_q;
  logic [BLOCK_W-1:0]   dispatched_q;
  logic [BLOCK_W-1:0]   completed_q;

  logic [NUM_CORES-1:0] release_c;
  logic [NUM_CORES-1:0] assign_c;
  logic [BLOCK_W-1:0]   release_cnt_c;
  logic [BLOCK_W-1:0]   tail_c;
  logic [CNT_W-1:0]     assign_cnt_c;
  logic                 can_assign_c;
  logic                 found_c;

  // lowest-index free core gets the next block; finishing cores are popcounted
  always_comb begin
    assign_c      = '0;
    release_cnt_c = '0;
    found_c       = 1'b0;
    can_assign_c  = (state == ST_DISPATCH) && (dispatched_q < total_q);
    for (int i = 0; i < NUM_CORES; i++) begin
      if (can_assign_c && core_reset[i] && !found_c) begin
        assign_c[i] = 1'b1;
        found_c     = 1'b1;
      end
      release_cnt_c = release_cnt_c + BLOCK_W'(release_c[i]);
    end
    tail_c       = tc_q - BLOCK_W'((total_q - BLOCK_W'(1)) << TPB_LOG2);
    assign_cnt_c = (dispatched_q == total_q - BLOCK_W'(1)) ? CNT_W'(tail_c)
                                                           : CNT_W'(THREADS_PER_BLOCK);
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    dispatch_slot #(.CNT_W(CNT_W)) u_slot (
      .clk               (clk),
      .reset             (reset),
      .assign_en         (assign_c[g]),
      .block_id          (dispatched_q),
      .thread_cnt        (assign_cnt_c),
      .core_done         (core_done[g]),
      .core_start        (core_start[g]),
      .core_reset        (core_reset[g]),
      .core_block_id     (core_block_id[g]),
      .core_thread_count (core_thread_count[g]),
      .release_c         (release_c[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      done         <= 1'b0;
      tc_q         <= '0;
      total_q      <= '0;
      dispatched_q <= '0;
      completed_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            tc_q         <= thread_count;
            total_q      <= block_count(thread_count, TPB_LOG2);
            dispatched_q <= '0;
            completed_q  <= '0;
            state        <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (|assign_c) dispatched_q <= dispatched_q + BLOCK_W'(1);
          completed_q <= completed_q + release_cnt_c;
          if (completed_q == total_q) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!start) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DISPATCH_PERF_EN
  // edges spent dispatching; frozen outside DISPATCH, restarted on launch
  always_ff @(posedge clk) begin
    if (reset) begin
      kernel_cycles <= '0;
    end else if (state == ST_IDLE && start) begin
      kernel_cycles <= '0;
    end else if (state == ST_DISPATCH && kernel_cycles != '1) begin
      kernel_cycles <= kernel_cycles + PERF_W'(1);
    end
  end
`endif

endmodule
